// File: rtl/rob_completion_unit.sv
// In-order reorder-buffer tracker: Dispatch allocates at the tail, Execute completes
// entries out of order, and the head retires in order or triggers a flush.
module rob_completion_unit #(
  parameter int ROB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(ROB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [4:0]       alloc_rd,
  input  logic [31:0]      alloc_pc,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             ex_valid,
  input  logic [IDX_W-1:0] entry_index,
  input  logic [31:0]      ex_val,
  input  logic             br_mispred,
  input  logic             exception,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_val,
  output logic             flush_valid,
  output logic [31:0]      flush_pc,
  output logic             exc_valid,
  output logic [31:0]      exc_pc,
  output logic [IDX_W:0]   count
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_ENTRIES);

  logic [ROB_ENTRIES-1:0] r_busy;
  logic [ROB_ENTRIES-1:0] r_done;
  logic [ROB_ENTRIES-1:0] r_mis;
  logic [ROB_ENTRIES-1:0] r_exc;
  logic [4:0]             r_rd  [ROB_ENTRIES];
  logic [31:0]            r_pc  [ROB_ENTRIES];
  logic [31:0]            r_val [ROB_ENTRIES];
  logic [IDX_W-1:0]       r_head;
  logic [IDX_W-1:0]       r_tail;
  logic [IDX_W:0]         r_count;

  logic w_head_rdy;
  logic w_head_exc;
  logic w_head_mis;
  logic w_flush;
  logic w_retire;
  logic w_alloc;
  logic w_complete;

  assign w_head_rdy = r_busy[r_head] & r_done[r_head];
  // Exception outranks mispredict when both flags are set on the head.
  assign w_head_exc = w_head_rdy & r_exc[r_head];
  assign w_head_mis = w_head_rdy & r_mis[r_head] & ~r_exc[r_head];
  assign w_flush    = w_head_exc | w_head_mis;
  assign w_retire   = w_head_rdy & ~w_flush;
  assign w_alloc    = alloc_valid & alloc_ready;
  assign w_complete = ex_valid & r_busy[entry_index];

  assign alloc_ready = (r_count < FULL_CNT) && !w_flush;
  assign alloc_idx   = r_tail;
  assign count       = r_count;

  always_comb begin
    commit_valid = 1'b0;
    commit_rd    = 5'd0;
    commit_val   = 32'd0;
    flush_valid  = w_flush;
    flush_pc     = 32'd0;
    exc_valid    = w_head_exc;
    exc_pc       = 32'd0;
    if (w_head_rdy && !w_head_exc) begin
      commit_valid = 1'b1;
      commit_rd    = r_rd[r_head];
      commit_val   = r_val[r_head];
    end
    if (w_head_exc) begin
      flush_pc = r_pc[r_head];
      exc_pc   = r_pc[r_head];
    end else if (w_head_mis) begin
      flush_pc = r_val[r_head];
    end
  end

  // Control state; a flushing head is cleared along with everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_done  <= '0;
      r_mis   <= '0;
      r_exc   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_busy  <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_complete) begin
        r_done[entry_index] <= 1'b1;
        r_mis[entry_index]  <= br_mispred;
        r_exc[entry_index]  <= exception;
      end
      if (w_alloc) begin
        r_busy[r_tail] <= 1'b1;
        r_done[r_tail] <= 1'b0;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_retire) begin
        r_busy[r_head] <= 1'b0;
        r_done[r_head] <= 1'b0;
        r_head         <= r_head + 1'b1;
      end
      r_count <= r_count + {{IDX_W{1'b0}}, w_alloc} - {{IDX_W{1'b0}}, w_retire};
    end
  end

  // Payload is only ever read behind busy/done, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_rd[r_tail] <= alloc_rd;
      r_pc[r_tail] <= alloc_pc;
    end
    if (w_complete) begin
      r_val[entry_index] <= ex_val;
    end
  end

endmodule

// File: doc/rob_completion_unit.md
Name: rob_completion_unit

Overview:
- ROB-side receiver for Execute completion writebacks (ex_valid, entry_index, ex_val, br_mispred, exception).
- Circular in-order tracker: Dispatch allocates entries; Execute marks them complete out of order; the head retires in order.
- A mispredicted or excepting head triggers a full flush and front-end redirect.

Parameters:
ROB_ENTRIES, 16, number of entries; power of two, ≥2
IDX_W, $clog2(ROB_ENTRIES), entry tag width

Ports:
clk  input  1  core clock
rst_n  input  1  synchronous active-low reset
alloc_valid  input  1  Dispatch requests an entry
alloc_ready  output  1  entry available and no flush this cycle
alloc_rd  input  5  destination register (0 = none)
alloc_pc  input  32  instruction PC
alloc_idx  output  IDX_W  tag granted (= tail), valid when alloc_ready
ex_valid  input  1  Execute completion strobe
entry_index  input  IDX_W  tag being completed
ex_val  input  32  result; corrected target PC when br_mispred=1
br_mispred  input  1  branch resolved mispredicted
exception  input  1  instruction faulted
commit_valid  output  1  head retires this cycle
commit_rd  output  5  head destination (0 when no regfile write)
commit_val  output  32  head result
flush_valid  output  1  pipeline flush this cycle
flush_pc  output  32  redirect PC
exc_valid  output  1  flush is due to exception
exc_pc  output  32  PC of faulting instruction
count  output  IDX_W+1  occupied entries

Behaviour:
- Per-entry state: busy, done, mispred, exc, rd, pc, val. Pointers head and tail are IDX_W wide and wrap naturally. The count register ranges 0..ROB_ENTRIES.
- Reset (rst_n=0 at posedge): head=tail=count=0 and all busy/done cleared. The resulting output values are:
  - alloc_ready=1 and alloc_idx=0.
  - commit_valid, flush_valid and exc_valid are 0.
  - commit_rd=0, commit_val=0, flush_pc=0, exc_pc=0.
- Reset overrides every concurrent alloc, completion and commit.
- Allocation:
  - alloc_ready = (count < ROB_ENTRIES) && !flush_valid. A retirement in the same cycle does not free space for that cycle's allocation.
  - On alloc_valid && alloc_ready at the edge, entry[tail] is written with busy=1, done=0, rd and pc; then tail++.
- Completion:
  - On ex_valid at the edge, entry[entry_index] takes done=1, val=ex_val, mispred=br_mispred, exc=exception.
  - A completion to a non-busy entry is ignored. A repeated completion to the same entry overwrites it (last write wins).
  - Completion is visible to retirement the cycle after the edge. There is no same-cycle bypass.
- Retirement is combinational from head state and occurs when entry[head] has busy && done:
  - Normal case: commit_valid=1, commit_rd=rd, commit_val=val. At the edge the entry is cleared, head++, count--.
  - Head mispredicted: commit_valid=1 (the branch retires with its rd/val; val here holds the target). flush_valid=1 and flush_pc=val.
  - Head exception: commit_valid=0 and commit_rd=0, so there is no architectural write. flush_valid=1, exc_valid=1, exc_pc=pc, flush_pc=pc.
  - When neither flag is set, flush_pc and exc_pc hold 0.
  - If exception and mispred are both set, exception takes priority.
- Flush edge: all busy/done are cleared and head=tail=count=0. Any same-cycle completion is discarded; allocation is already blocked via alloc_ready.
- Same-cycle allocation and retirement (no flush): count stays unchanged and both pointers advance.
- Pending counts: at most one retirement per cycle, so any other done entries behind the head wait.
- Output defaults: when no retirement occurs, commit_rd=0 and commit_val=0.

Test Plan:
ROB_ENTRIES=4 for all scenarios.
1. Reset, then allocate 4 entries with PCs 0x100, 0x104, 0x108, 0x10C → alloc_idx 0,1,2,3; count=4; alloc_ready=0 on the 5th request.
2. Out-of-order completion: complete idx2 (val 0x22), then idx0 (0x11), then idx1 (0x33) → commit_val order is 0x11, 0x33, 0x22, one per cycle; each commit_valid appears the cycle after its gating completion.
3. Mispredict: idx1 completes with br_mispred=1, ex_val=0x400 → at its retirement commit_valid=1, flush_valid=1, flush_pc=0x400; next cycle count=0, alloc_idx=0, and a later completion to idx2 is ignored.
4. Exception: idx0 (pc 0x100) completes with exception=1, rd=5 → commit_valid=0, exc_valid=1, exc_pc=0x100, flush_pc=0x100; alloc_valid in the flush cycle is not accepted.
5. Wrap and simultaneity: steady state at count=3 with one allocation and one retirement per cycle for 10 cycles → tail wraps 3→0, count stays 3, and the sequence of retired tags is contiguous mod 4.
6. Reset mid-run with 3 busy entries and ex_valid=1 on the reset edge → all outputs at reset values and count=0 the following cycle.
